// File: rtl/elastic_pipe_fifo_pkg.sv
// Shared pipeline package: stage payload widths, tag widths and a saturating adder.
package pipe_pkg;

  localparam int FETCH_W   = 41;
  localparam int DECODE_W  = 65;
  localparam int RENAME_W  = 41;
  localparam int PREG_W    = 7;
  localparam int ROB_TAG_W = 4;
  localparam int PC_W      = 9;

  // Saturates at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/elastic_pipe_fifo_if.sv
// Ready/valid bundle for both sides of the elastic buffer.
interface elastic_pipe_fifo_if
  import pipe_pkg::*;
#(
  parameter int DWIDTH = FETCH_W
);
  logic [DWIDTH-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [DWIDTH-1:0] o_data;
  logic              o_valid;
  logic              i_ready;

  modport master (output i_data, i_valid, i_ready, input o_ready, o_data, o_valid);
  modport slave  (input i_data, i_valid, i_ready, output o_ready, o_data, o_valid);
endinterface

// File: rtl/elastic_pipe_fifo_ring_ptr.sv
// Wrap-around ring pointer with clear priority over increment.
module ring_ptr
  import pipe_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);
  logic [W-1:0] ptr_reg;
  logic [W-1:0] ptr_next;

  // Power-of-two depth lets the natural binary overflow do the wrap.
  always_comb begin
    ptr_next = ptr_reg;
    if (clr) begin
      ptr_next = '0;
    end else if (inc) begin
      ptr_next = ptr_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;
endmodule

// File: rtl/elastic_pipe_fifo.sv
// Flushable elastic pipeline buffer; ELASTIC_PIPE_FIFO_PERF_EN adds stall/flush counters.
module elastic_pipe_fifo
  import pipe_pkg::*;
#(
  parameter int DWIDTH = FETCH_W,
  parameter int DEPTH  = 4,
  parameter int CNTW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  elastic_pipe_fifo_if.slave bus,
  output logic [CNTW-1:0] count
`ifdef ELASTIC_PIPE_FIFO_PERF_EN
  ,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     flushed_words
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CNTW-1:0] FULL_CNT = CNTW'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [CNTW-1:0]   count_reg;
  logic [CNTW-1:0]   count_next;
  logic              push;
  logic              pop;
  logic [PW-1:0]     ptr_arr [2];
  logic              inc_arr [2];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  // Handshakes depend only on registered occupancy, so i_ready never reaches o_ready.
  assign bus.o_ready = (count_reg != FULL_CNT);
  assign bus.o_valid = (count_reg != '0);
  assign push        = bus.i_valid & bus.o_ready;
  assign pop         = bus.o_valid & bus.i_ready;

  assign inc_arr[0] = pop;
  assign inc_arr[1] = push;
  assign rd_ptr     = ptr_arr[0];
  assign wr_ptr     = ptr_arr[1];

  // Index 0 is the read pointer, index 1 the write pointer.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
      ring_ptr #(.W(PW)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (inc_arr[gi]),
        .clr   (flush),
        .ptr   (ptr_arr[gi])
      );
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // A push coinciding with flush is dropped, so it must not touch storage.
  always_ff @(posedge clk) begin
    if (push && !flush && reset) begin
      mem[wr_ptr] <= bus.i_data;
    end
  end

  assign bus.o_data = (count_reg == '0) ? '0 : mem[rd_ptr];
  assign count      = count_reg;

`ifdef ELASTIC_PIPE_FIFO_PERF_EN
  logic [31:0] stall_reg;
  logic [31:0] flushed_reg;

  // Flush clears occupancy but deliberately leaves the statistics running.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_reg   <= '0;
      flushed_reg <= '0;
    end else begin
      if (bus.i_valid && !bus.o_ready) begin
        stall_reg <= sat_add32(stall_reg, 32'd1);
      end
      if (flush) begin
        flushed_reg <= sat_add32(flushed_reg, 32'(count_reg));
      end
    end
  end

  assign stall_cycles  = stall_reg;
  assign flushed_words = flushed_reg;
`endif
endmodule

// File: tb/tb_elastic_pipe_fifo.sv
// Randomized and directed bench for elastic_pipe_fifo against a queue-based reference.
module tb_elastic_pipe_fifo;
  localparam int DW    = 41;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic [CW-1:0] count;
`ifdef ELASTIC_PIPE_FIFO_PERF_EN
  logic [31:0]   stall_cycles;
  logic [31:0]   flushed_words;
`endif

  elastic_pipe_fifo_if #(.DWIDTH(DW)) bus ();

  elastic_pipe_fifo #(.DWIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus.slave),
    .count (count)
`ifdef ELASTIC_PIPE_FIFO_PERF_EN
    ,
    .stall_cycles  (stall_cycles),
    .flushed_words (flushed_words)
`endif
  );

  always #5 clk = ~clk;

  int unsigned   err_cnt = 0;
  int unsigned   chk_cnt = 0;
  logic [DW-1:0] model_q [$];
  longint        stall_m = 0;
  longint        flushed_m = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Drives one cycle, advances the reference queue, then compares every output.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ir,
                      input logic fl, input logic rs, input bit verbose);
    bit            acc;
    bit            del;
    logic [DW-1:0] head;
    bus.i_valid = iv;
    bus.i_data  = d;
    bus.i_ready = ir;
    flush       = fl;
    reset       = rs;
    acc  = iv && (model_q.size() < DEPTH);
    del  = ir && (model_q.size() > 0);
    head = (model_q.size() > 0) ? model_q[0] : '0;
    if (!rs) begin
      stall_m   = 0;
      flushed_m = 0;
    end else begin
      if (iv && model_q.size() == DEPTH) stall_m++;
      if (fl) flushed_m += model_q.size();
    end
    @(posedge clk);
    #1;
    if (!rs || fl) begin
      model_q.delete();
    end else begin
      if (del) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
    if (verbose)
      $display("txn t=%0t rst_n=%0b flush=%0b push=%0b(0x%0h) pop=%0b(0x%0h) count=%0d",
               $time, rs, fl, acc && rs && !fl, d, del && rs, head, count);
    check_val("count", 64'(count), 64'(model_q.size()));
    check_val("o_valid", 64'(bus.o_valid), 64'(model_q.size() != 0));
    check_val("o_ready", 64'(bus.o_ready), 64'(model_q.size() != DEPTH));
    check_val("o_data", 64'(bus.o_data), 64'((model_q.size() > 0) ? model_q[0] : '0));
`ifdef ELASTIC_PIPE_FIFO_PERF_EN
    check_val("stall_cycles", 64'(stall_cycles), 64'(stall_m));
    check_val("flushed_words", 64'(flushed_words), 64'(flushed_m));
`endif
  endtask

  initial begin
    logic [DW-1:0] rnd;
    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    flush       = 1'b0;
    reset       = 1'b0;

    // Reset state.
    step(0, '0, 0, 0, 0, 1);
    step(0, '0, 0, 0, 0, 1);

    // Fill to DEPTH with downstream stalled, then offer a word that must be held.
    step(1, 41'h11, 0, 0, 1, 1);
    step(1, 41'h22, 0, 0, 1, 1);
    step(1, 41'h33, 0, 0, 1, 1);
    step(1, 41'h44, 0, 0, 1, 1);
    step(1, 41'h55, 0, 0, 1, 1);
    check_val("full_o_ready", 64'(bus.o_ready), 64'd0);

    // Drain while 0x55 is offered; it enters only after the first pop frees a slot.
    step(1, 41'h55, 1, 0, 1, 1);
    check_val("blocked_55_count", 64'(count), 64'd3);
    step(1, 41'h55, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 1, 1);
    check_val("drained", 64'(count), 64'd0);

    // Streaming: 100 words through, wrapping the pointers many times.
    for (int i = 0; i < 100; i++) step(1, DW'(i + 1), 1, 0, 1, 0);
    step(0, '0, 1, 0, 1, 1);

    // Flush with count==3 drops the concurrent push of 0xAA.
    for (int i = 0; i < 3; i++) step(1, DW'(41'hA0 + i), 0, 0, 1, 1);
    step(1, 41'hAA, 0, 1, 1, 1);
    check_val("post_flush_count", 64'(count), 64'd0);
    step(0, '0, 1, 0, 1, 1);
    step(0, '0, 1, 1, 1, 1);

    // Reset overrides flush mid-stream; 0x77 is then the first word out.
    step(1, 41'h61, 0, 0, 1, 1);
    step(1, 41'h62, 0, 0, 1, 1);
    step(1, 41'h63, 1, 1, 0, 1);
    step(1, 41'h77, 0, 0, 1, 1);
    check_val("first_after_reset", 64'(bus.o_data), 64'h77);
    step(0, '0, 1, 0, 1, 1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 10000; i++) begin
      rnd = {$urandom, $urandom};
      step(1'($urandom_range(0, 1)), rnd, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 99) < 5), 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/elastic_pipe_fifo.md
Name: elastic_pipe_fifo

Overview:
- Parametrised, flushable elastic buffer between pipeline stages (fetch/decode/rename/dispatch).
- Next-generation replacement for the 2-entry skid buffer, with configurable depth, a mispredict flush and an occupancy output.
- Ready/valid on both sides.
- No combinational path from downstream i_ready to upstream o_ready.

Parameters:
- DWIDTH, 41, payload width in bits (≥1).
- DEPTH, 4, number of entries; power of two, ≥2.
- CNTW, $clog2(DEPTH)+1, width of the count output (derived; do not override).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  branch-mispredict flush; discards all held entries.
- i_data  in  DWIDTH  upstream payload.
- i_valid  in  1  upstream payload valid.
- o_ready  out  1  buffer can accept this cycle.
- o_data  out  DWIDTH  head-entry payload.
- o_valid  out  1  head entry valid.
- i_ready  in  1  downstream accepts head this cycle.
- count  out  CNTW  number of valid entries, 0..DEPTH.

Behaviour:
- Storage: circular array of DEPTH entries; rd_ptr/wr_ptr are $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count register is CNTW bits.
- Reset (reset==0 at a clk edge): rd_ptr=wr_ptr=0, count=0. Outputs: o_valid=0, o_ready=1, count=0, o_data=0. Array contents are don't-care. Reset overrides flush and any handshake in the same cycle.
- push = i_valid & o_ready. pop = o_valid & i_ready.
- o_ready = (count != DEPTH), derived only from registered state.
- o_valid = (count != 0), derived only from registered state.
- o_data = mem[rd_ptr]; forced to 0 when count==0.
- Latency: a word accepted at edge N is visible on o_data/o_valid after edge N (available from cycle N+1). No same-cycle bypass.
- Simultaneous push and pop, 0 < count < DEPTH: count unchanged, both pointers advance.
- count==0: pop impossible; push -> count=1.
- count==DEPTH: push blocked (o_ready=0) even if i_ready=1 that cycle; the pop proceeds and o_ready returns to 1 the following cycle.
- Ordering: strict FIFO; every accepted word is delivered exactly once unless flushed.
- Flush (reset==1, flush==1 at an edge): rd_ptr=wr_ptr=0, count=0.
  - Any push in that cycle is dropped.
  - A pop in that cycle is still a completed downstream handshake; downstream owns squashing it.
  - o_valid=0 from the next cycle.
- Flush asserted on consecutive cycles keeps the buffer empty.
- Flush with count==0 is a no-op.
- Invariant: count == (wr_ptr - rd_ptr) mod DEPTH, except count==DEPTH when pointers are equal and the buffer is full.

Optional Feature:
- Macro: ELASTIC_PIPE_FIFO_PERF_EN.
- Defined: adds output ports stall_cycles (32) and flushed_words (32).
  - stall_cycles increments each cycle with i_valid & !o_ready.
  - flushed_words adds the pre-flush count on each flush.
  - Both saturate at 32'hFFFF_FFFF and clear on reset, not on flush.
- Undefined: ports and counters are absent; the functional behaviour above is identical.

Decomposition:
- Shared package pipe_pkg:
  - payload widths FETCH_W=41, DECODE_W=65, RENAME_W=41;
  - PREG_W=7, ROB_TAG_W=4, PC_W=9.
- One natural sub-module, ring_ptr: a parametrised wrap-around pointer with inc, clr and ptr out, instantiated twice for rd and wr.
- Count and flush logic stay in the parent.

Test Plan:
- Reset, then DEPTH=4, i_ready=0, push 0x11,0x22,0x33,0x44 -> count 1..4; o_ready=0 after 4th; 5th word 0x55 held, not accepted.
- Full buffer, i_ready=1 for 5 cycles, i_valid=1 with 0x55 -> outputs 0x11,0x22,0x33,0x44,0x55 in order; 0x55 accepted one cycle after first pop; count never exceeds 4.
- Streaming, i_valid=i_ready=1, 100 incrementing words -> count stays 1 after first cycle; output equals input delayed 1 cycle; pointers wrap 25 times without loss.
- count=3, flush=1 with i_valid=1 data 0xAA -> next cycle count=0, o_valid=0, o_ready=1; 0xAA never appears.
- reset=0 asserted mid-stream with count=2 and flush=1 -> all outputs at reset values next cycle; first post-reset push 0x77 is the first word output.
- Random i_valid/i_ready/flush (flush 5%), 10k cycles, scoreboard with flush-aware model -> no loss, duplication or reorder; with ELASTIC_PIPE_FIFO_PERF_EN, stall_cycles matches model.
